// File: rtl/conv_unit.sv
// Pipelined 3x3 signed multiply-accumulate: products, row partial sums,
// saturated total, then an output register that only loads on valid results.
module conv_unit #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic signed [DATA_WIDTH-1:0]   window  [0:8],
  input  logic signed [WEIGHT_WIDTH-1:0] weights [0:8],
  input  logic signed [WEIGHT_WIDTH-1:0] bias,
  input  logic                           valid_in,
  output logic signed [ACC_WIDTH-1:0]    conv_out,
  output logic                           valid_out
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int SW = PW + 2;
  localparam int TW = PW + 5;
  localparam int XW = (ACC_WIDTH > TW) ? ACC_WIDTH : TW;
  localparam logic signed [XW-1:0] MAXV = XW'((64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] MINV = XW'(-(64'sd1 <<< (ACC_WIDTH - 1)));

  logic signed [PW-1:0]           prod_d [0:8];
  logic signed [PW-1:0]           prod_q [0:8];
  logic signed [WEIGHT_WIDTH-1:0] bias1_q;
  logic                           v1_q;

  logic signed [SW-1:0]           psum_d [0:2];
  logic signed [SW-1:0]           psum_q [0:2];
  logic signed [SW-1:0]           bias2_q;
  logic                           v2_q;

  logic signed [XW-1:0]           total;
  logic signed [ACC_WIDTH-1:0]    res3_d;
  logic signed [ACC_WIDTH-1:0]    res3_q;
  logic                           v3_q;

  logic signed [ACC_WIDTH-1:0]    conv_q;
  logic                           vout_q;

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      prod_d[i] = PW'(window[i]) * PW'(weights[i]);
    end
    psum_d[0] = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]);
    psum_d[1] = SW'(prod_q[3]) + SW'(prod_q[4]) + SW'(prod_q[5]);
    psum_d[2] = SW'(prod_q[6]) + SW'(prod_q[7]) + SW'(prod_q[8]);

    total = XW'(psum_q[0]) + XW'(psum_q[1]) + XW'(psum_q[2]) + XW'(bias2_q);
    if (total > MAXV) begin
      res3_d = ACC_WIDTH'(MAXV);
    end else if (total < MINV) begin
      res3_d = ACC_WIDTH'(MINV);
    end else begin
      res3_d = ACC_WIDTH'(total);
    end
  end

  // Stage 3 is registered so the result reaches conv_out three edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 9; i++) begin
        prod_q[i] <= '0;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        psum_q[r] <= '0;
      end
      bias1_q <= '0;
      bias2_q <= '0;
      res3_q  <= '0;
      conv_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      vout_q  <= 1'b0;
    end else if (enable) begin
      prod_q  <= prod_d;
      bias1_q <= bias;
      v1_q    <= valid_in;
      psum_q  <= psum_d;
      bias2_q <= SW'(bias1_q);
      v2_q    <= v1_q;
      res3_q  <= res3_d;
      v3_q    <= v2_q;
      vout_q  <= v3_q;
      if (v3_q) begin
        conv_q <= res3_q;
      end
    end
  end

  assign conv_out  = conv_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_conv_unit.sv
// Randomised and directed bench for conv_unit at ACC_WIDTH 20 and 16, against a queue-based model.
module tb_conv_unit;

  logic clk = 1'b0;
  logic rst_n, enable, valid_in;
  logic signed [7:0]  win [0:8];
  logic signed [7:0]  wts [0:8];
  logic signed [7:0]  bias;
  logic signed [19:0] conv20;
  logic signed [15:0] conv16;
  logic               vo20, vo16;

  conv_unit #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .window(win), .weights(wts),
    .bias(bias), .valid_in(valid_in), .conv_out(conv20), .valid_out(vo20));

  conv_unit #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .window(win), .weights(wts),
    .bias(bias), .valid_in(valid_in), .conv_out(conv16), .valid_out(vo16));

  always #5 clk = ~clk;

  typedef struct {
    int                 due;
    logic signed [19:0] v20;
    logic signed [15:0] v16;
  } beat_t;

  beat_t              pend[$];
  int                 adv, cyc, checks, failures;
  logic               exp_vo;
  logic signed [19:0] exp20;
  logic signed [15:0] exp16;

  function automatic logic signed [63:0] ref_sum();
    logic signed [63:0] s;
    s = 64'(bias);
    for (int i = 0; i < 9; i++) s += 64'(win[i]) * 64'(wts[i]);
    return s;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction

  task automatic set_uniform(input int p, input int w, input int b);
    for (int i = 0; i < 9; i++) begin
      win[i] = 8'(p);
      wts[i] = 8'(w);
    end
    bias = 8'(b);
  endtask

  task automatic set_rand();
    for (int i = 0; i < 9; i++) begin
      win[i] = 8'($urandom);
      wts[i] = 8'($urandom);
    end
    bias = 8'($urandom);
  endtask

  task automatic model_reset();
    pend.delete();
    exp_vo = 1'b0;
    exp20  = '0;
    exp16  = '0;
  endtask

  // Drives one clock edge; a beat emerges after its third enabled edge past acceptance.
  task automatic step(input bit en, input bit vin);
    enable   = en;
    valid_in = vin;
    @(posedge clk);
    cyc++;
    if (rst_n && en) begin
      adv++;
      if (pend.size() > 0 && pend[0].due == adv) begin
        beat_t b = pend.pop_front();
        exp_vo = 1'b1;
        exp20  = b.v20;
        exp16  = b.v16;
      end else begin
        exp_vo = 1'b0;
      end
      if (vin) begin
        beat_t nb;
        nb.due = adv + 3;
        nb.v20 = 20'(sat(ref_sum(), 20));
        nb.v16 = 16'(sat(ref_sum(), 16));
        pend.push_back(nb);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b0; valid_in = 1'b0;
    set_uniform(0, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    checks += 4;
    if (vo20 !== 1'b0)   begin failures++; $display("FAIL reset_vo20 got=%0b exp=0", vo20); end
    if (vo16 !== 1'b0)   begin failures++; $display("FAIL reset_vo16 got=%0b exp=0", vo16); end
    if (conv20 !== 20'sd0) begin failures++; $display("FAIL reset_conv20 got=%0d exp=0", conv20); end
    if (conv16 !== 16'sd0) begin failures++; $display("FAIL reset_conv16 got=%0d exp=0", conv16); end
    step(1, 1);
    step(1, 1);
    rst_n = 1'b1;
    adv = 0;
  endtask

  task automatic test_identity();
    int acc, at, pulses;
    pulses = 0; at = -1;
    set_uniform(0, 0, 0);
    win[4] = 8'sd100; wts[4] = 8'sd1;
    for (int c = 0; c < 7; c++) begin
      step(1, c == 0);
      if (c == 0) begin acc = cyc; set_rand(); end
      checks += 3;
      if (vo20 !== exp_vo)  begin failures++; $display("FAIL ident_valid cyc=%0d got=%0b exp=%0b", cyc, vo20, exp_vo); end
      if (conv20 !== exp20) begin failures++; $display("FAIL ident_conv20 cyc=%0d got=%0d exp=%0d", cyc, conv20, exp20); end
      if (conv16 !== exp16) begin failures++; $display("FAIL ident_conv16 cyc=%0d got=%0d exp=%0d", cyc, conv16, exp16); end
      if (vo20 === 1'b1) begin pulses++; at = cyc; end
    end
    checks += 3;
    if (pulses != 1)      begin failures++; $display("FAIL ident_pulses got=%0d exp=1", pulses); end
    if (at - acc != 3)    begin failures++; $display("FAIL ident_latency got=%0d exp=3", at - acc); end
    if (conv20 !== 20'sd100) begin failures++; $display("FAIL ident_value got=%0d exp=100", conv20); end
  endtask

  task automatic test_uniform();
    set_uniform(10, 1, 5);
    for (int c = 0; c < 6; c++) begin
      step(1, c == 0);
      checks += 3;
      if (vo20 !== exp_vo)  begin failures++; $display("FAIL unif_valid cyc=%0d got=%0b exp=%0b", cyc, vo20, exp_vo); end
      if (conv20 !== exp20) begin failures++; $display("FAIL unif_conv20 cyc=%0d got=%0d exp=%0d", cyc, conv20, exp20); end
      if (conv16 !== exp16) begin failures++; $display("FAIL unif_conv16 cyc=%0d got=%0d exp=%0d", cyc, conv16, exp16); end
    end
    checks++;
    if (conv20 !== 20'sd95) begin failures++; $display("FAIL unif_value got=%0d exp=95", conv20); end
  endtask

  task automatic test_extremes();
    int k;
    logic signed [19:0] c20 [0:1];
    logic signed [15:0] c16 [0:1];
    c20[0] = 20'sd147583;  c20[1] = -20'sd146432;
    c16[0] = 16'sd32767;   c16[1] = -16'sd32768;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) set_uniform(-128, -128, 127);
      if (c == 1) set_uniform(-128, 127, -128);
      step(1, c < 2);
      checks += 2;
      if (vo20 !== exp_vo)  begin failures++; $display("FAIL ext_valid cyc=%0d got=%0b exp=%0b", cyc, vo20, exp_vo); end
      if (vo16 !== exp_vo)  begin failures++; $display("FAIL ext_valid16 cyc=%0d got=%0b exp=%0b", cyc, vo16, exp_vo); end
      if (vo20 === 1'b1 && k < 2) begin
        checks += 2;
        if (conv20 !== c20[k]) begin failures++; $display("FAIL ext_conv20 k=%0d got=%0d exp=%0d", k, conv20, c20[k]); end
        if (conv16 !== c16[k]) begin failures++; $display("FAIL ext_sat16 k=%0d got=%0d exp=%0d", k, conv16, c16[k]); end
        k++;
      end
    end
    checks++;
    if (k != 2) begin failures++; $display("FAIL ext_count got=%0d exp=2", k); end
  endtask

  task automatic test_back_to_back();
    int k, first;
    k = 0; first = -1;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) set_uniform(c + 1, 1, 0);
      step(1, c < 3);
      checks += 2;
      if (vo20 !== exp_vo)  begin failures++; $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", cyc, vo20, exp_vo); end
      if (conv20 !== exp20) begin failures++; $display("FAIL b2b_conv20 cyc=%0d got=%0d exp=%0d", cyc, conv20, exp20); end
      if (vo20 === 1'b1) begin
        if (k == 0) first = cyc;
        checks += 2;
        if (conv20 !== 20'(9 * (k + 1))) begin failures++; $display("FAIL b2b_order k=%0d got=%0d exp=%0d", k, conv20, 9 * (k + 1)); end
        if (cyc != first + k) begin failures++; $display("FAIL b2b_gap k=%0d got=%0d exp=%0d", k, cyc, first + k); end
        k++;
      end
    end
    checks++;
    if (k != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", k); end
  endtask

  task automatic test_stall();
    int acc, at, pulses;
    pulses = 0; at = -1;
    for (int c = 0; c < 10; c++) begin
      set_rand();
      step(!(c == 1 || c == 2), 1'b1 && (c == 0 || c == 1 || c == 2));
      if (c == 0) acc = cyc;
      checks += 3;
      if (vo20 !== exp_vo)  begin failures++; $display("FAIL stall_valid cyc=%0d got=%0b exp=%0b", cyc, vo20, exp_vo); end
      if (conv20 !== exp20) begin failures++; $display("FAIL stall_conv20 cyc=%0d got=%0d exp=%0d", cyc, conv20, exp20); end
      if (conv16 !== exp16) begin failures++; $display("FAIL stall_conv16 cyc=%0d got=%0d exp=%0d", cyc, conv16, exp16); end
      if (vo20 === 1'b1) begin pulses++; if (at < 0) at = cyc; end
    end
    checks += 2;
    if (pulses != 1)   begin failures++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    if (at - acc != 5) begin failures++; $display("FAIL stall_latency got=%0d exp=5", at - acc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_rand();
      if ($urandom_range(0, 7) == 0) set_uniform(-128, ($urandom_range(0, 1) != 0) ? -128 : 127, 127);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      checks += 4;
      if (vo20 !== exp_vo)  begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, vo20, exp_vo); end
      if (vo16 !== exp_vo)  begin failures++; $display("FAIL rand_valid16 cyc=%0d got=%0b exp=%0b", cyc, vo16, exp_vo); end
      if (conv20 !== exp20) begin failures++; $display("FAIL rand_conv20 cyc=%0d got=%0d exp=%0d", cyc, conv20, exp20); end
      if (conv16 !== exp16) begin failures++; $display("FAIL rand_conv16 cyc=%0d got=%0d exp=%0d", cyc, conv16, exp16); end
    end
    for (int c = 0; c < 6; c++) step(1, 0);
  endtask

  task automatic test_reset_midflight();
    set_uniform(3, 3, 1);
    step(1, 1);
    step(1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks += 3;
    if (vo20 !== 1'b0)     begin failures++; $display("FAIL mid_valid got=%0b exp=0", vo20); end
    if (conv20 !== 20'sd0) begin failures++; $display("FAIL mid_conv20 got=%0d exp=0", conv20); end
    if (conv16 !== 16'sd0) begin failures++; $display("FAIL mid_conv16 got=%0d exp=0", conv16); end
    step(1, 1);
    step(1, 1);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_uniform(2, -3, 7);
      step(1, c == 4);
      checks += 3;
      if (vo20 !== exp_vo)  begin failures++; $display("FAIL mid_after_valid cyc=%0d got=%0b exp=%0b", cyc, vo20, exp_vo); end
      if (conv20 !== exp20) begin failures++; $display("FAIL mid_after_conv20 cyc=%0d got=%0d exp=%0d", cyc, conv20, exp20); end
      if (conv16 !== exp16) begin failures++; $display("FAIL mid_after_conv16 cyc=%0d got=%0d exp=%0d", cyc, conv16, exp16); end
    end
    checks++;
    if (conv20 !== -20'sd47) begin failures++; $display("FAIL mid_after_value got=%0d exp=-47", conv20); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; adv = 0;
    model_reset();
    test_reset();
    test_identity();
    test_uniform();
    test_extremes();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_unit.md
# conv_unit

Pipelined 3x3 signed multiply-accumulate engine for the CNN datapath. Each accepted beat takes a 9-pixel window, 9 kernel weights and a bias, and produces one convolution result: sum of window[i]*weights[i] plus bias. It sits between the line-buffer/window generator and the activation/pooling stages. It is fully pipelined and accepts one new window per cycle.

## Interface
- DATA_WIDTH, 8: signed pixel width.
- WEIGHT_WIDTH, 8: signed weight and bias width.
- ACC_WIDTH, 20: signed output width. Must be >= DATA_WIDTH+WEIGHT_WIDTH.

- clk  input  1: single clock; all state updates on its rising edge.
- rst_n  input  1: reset, asynchronous and active-low.
- enable  input  1: pipeline advance; when low the whole pipeline stalls.
- window  input  9 x DATA_WIDTH signed (unpacked array [0:8]): pixels in row-major order; index 4 is the centre.
- weights  input  9 x WEIGHT_WIDTH signed (unpacked array [0:8]): kernel, index-aligned with window.
- bias  input  WEIGHT_WIDTH signed: added unscaled to the sum.
- valid_in  input  1: window, weights and bias are valid this cycle.
- conv_out  output  ACC_WIDTH signed: registered result.
- valid_out  output  1: conv_out carries a new result this cycle.

## Operation
- **Accept condition:** a beat is accepted on a rising edge with enable=1 and valid_in=1. All inputs are sampled on that edge; no input needs to be held afterwards.
- **Stage 1:** register nine full-precision signed products, each DATA_WIDTH+WEIGHT_WIDTH bits. Register the valid bit alongside them.
- **Stage 2:** add the products in three row groups (0-2, 3-5, 6-8) at width DATA_WIDTH+WEIGHT_WIDTH+2, and register the partial sums. The sign-extended bias and the valid bit travel with this stage.
- **Stage 3:** add the three partial sums and the sign-extended bias at internal width DATA_WIDTH+WEIGHT_WIDTH+5, so nothing overflows internally. Then saturate to ACC_WIDTH:
  - values above 2^(ACC_WIDTH-1)-1 clamp to that value;
  - values below -2^(ACC_WIDTH-1) clamp to that value.
- **Output register:** conv_out loads the result only on the edge where the stage-3 valid is set. Otherwise it holds its last value.
- **valid_out:** asserts for one cycle per accepted beat. Results leave in acceptance order.
- **Invalid beats:** data registers of invalid beats may update freely, but must never raise valid_out.
- **Stall:** with enable=0, every pipeline register holds, including conv_out and valid_out. Inputs are ignored. Advance resumes on the first edge with enable=1, with no loss or duplication of in-flight beats.
- **Example values:** identity kernel (weights[4]=1, others 0) returns window[4]. Bias is not shifted or scaled.

## Timing
- **Latency:** 3 cycles. A beat accepted at edge N gives valid_out=1 and conv_out valid after edge N+3, assuming enable stays high.
- **Stall cycles:** each enable=0 cycle inside that window adds one cycle of latency.
- **Throughput:** 1 beat/cycle. Back-to-back valid_in produces back-to-back valid_out.
- **Reset:** rst_n=0 asynchronously clears:
  - all valid bits;
  - valid_out=0;
  - conv_out=0;
  - all product and partial-sum registers.
- **Reset mid-operation:** in-flight beats are discarded and no valid_out is produced for them. The first beat accepted after reset release follows normal latency.
- **Simultaneous events:** enable=0 together with valid_in=1 means the beat is not accepted.

## Test plan
- **Identity kernel:** window[4]=100, other pixels 0; weights[4]=1, other weights 0; bias=0; one valid_in pulse -> conv_out=100 with valid_out high for exactly 1 cycle, 3 cycles after acceptance.
- **Uniform sum:** all pixels=10, all weights=1, bias=5 -> conv_out=95.
- **Signed extremes, default widths:** all pixels=-128, all weights=-128, bias=127 -> 147583. Then all pixels=-128, all weights=127, bias=-128 -> -146432.
- **Saturation at ACC_WIDTH=16:** the first case above -> 32767. The second case -> -32768.
- **Back-to-back:** 3 consecutive beats with uniform pixels 1, 2, 3, weights=1, bias=0 -> valid_out high 3 consecutive cycles with conv_out 9, 18, 27 in order.
- **Stall and reset:**
  - Drop enable for 2 cycles after accepting a beat -> result arrives 5 cycles after acceptance, and valid_out is never lost or doubled.
  - Assert rst_n low while a beat is in flight -> conv_out=0, valid_out=0 immediately, and no late valid_out for that beat.
